// File: rtl/can_rx_msg_buffer_ctrl.sv
// CAN receive message controller: captures completed frames, applies a standard-ID
// acceptance filter and queues accepted frames in a DEPTH-entry FIFO drained by the host.
module can_rx_msg_buffer_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_done,
    input  logic [10:0]                rx_id_std,
    input  logic                       rx_rtr,
    input  logic                       rx_ide,
    input  logic [3:0]                 rx_dlc,
    input  logic [63:0]                rx_data,
    input  logic                       cfg_filter_en,
    input  logic [10:0]                cfg_acc_code,
    input  logic [10:0]                cfg_acc_mask,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [10:0]                rd_id,
    output logic                       rd_rtr,
    output logic                       rd_ide,
    output logic [3:0]                 rd_dlc,
    output logic [63:0]                rd_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overrun,
    input  logic                       clr_overrun,
    output logic                       msg_accepted,
    output logic                       msg_rejected
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILTER = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [10:0]   stg_id_reg;
    logic          stg_rtr_reg;
    logic          stg_ide_reg;
    logic [3:0]    stg_dlc_reg;
    logic [63:0]   stg_data_reg;
    logic [63:0]   clean_data;

    logic [10:0]   mem_id   [DEPTH];
    logic          mem_rtr  [DEPTH];
    logic          mem_ide  [DEPTH];
    logic [3:0]    mem_dlc  [DEPTH];
    logic [63:0]   mem_data [DEPTH];

    logic [AW-1:0] wptr_reg, rptr_reg;
    logic [CW-1:0] count_reg;
    logic          overrun_reg;

    logic          full, accept, push, pop, overrun_set;

    // Byte 0 sits in the top byte; bytes beyond the DLC (or all bytes of a remote frame) read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sanitise
            assign clean_data[63-8*gi -: 8] =
                (!rx_rtr && (rx_dlc > 4'(gi))) ? rx_data[63-8*gi -: 8] : 8'h00;
        end
    endgenerate

    assign full        = (count_reg == CW'(DEPTH));
    assign accept      = !cfg_filter_en || (((stg_id_reg ^ cfg_acc_code) & cfg_acc_mask) == 11'd0);
    assign push        = (state_reg == WRITE) && !full;
    assign pop         = (count_reg != '0) && rd_ready;
    assign overrun_set = ((state_reg == WRITE) && full) || (rx_done && (state_reg != IDLE));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rx_done) state_next = FILTER;
            FILTER:  state_next = accept ? WRITE : IDLE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            stg_id_reg   <= '0;
            stg_rtr_reg  <= 1'b0;
            stg_ide_reg  <= 1'b0;
            stg_dlc_reg  <= '0;
            stg_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && rx_done) begin
                stg_id_reg   <= rx_id_std;
                stg_rtr_reg  <= rx_rtr;
                stg_ide_reg  <= rx_ide;
                stg_dlc_reg  <= rx_dlc;
                stg_data_reg <= clean_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_id[i]   <= '0;
                mem_rtr[i]  <= 1'b0;
                mem_ide[i]  <= 1'b0;
                mem_dlc[i]  <= '0;
                mem_data[i] <= '0;
            end
        end else if (push) begin
            mem_id[wptr_reg]   <= stg_id_reg;
            mem_rtr[wptr_reg]  <= stg_rtr_reg;
            mem_ide[wptr_reg]  <= stg_ide_reg;
            mem_dlc[wptr_reg]  <= stg_dlc_reg;
            mem_data[wptr_reg] <= stg_data_reg;
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never makes room for a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push) wptr_reg <= wptr_reg + AW'(1);
            if (pop)  rptr_reg <= rptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (overrun_set)      overrun_reg <= 1'b1;
            else if (clr_overrun) overrun_reg <= 1'b0;
        end
    end

    assign rd_valid     = (count_reg != '0);
    assign rd_id        = mem_id[rptr_reg];
    assign rd_rtr       = mem_rtr[rptr_reg];
    assign rd_ide       = mem_ide[rptr_reg];
    assign rd_dlc       = mem_dlc[rptr_reg];
    assign rd_data      = mem_data[rptr_reg];
    assign fifo_count   = count_reg;
    assign overrun      = overrun_reg;
    assign msg_accepted = push;
    assign msg_rejected = (state_reg == FILTER) && !accept;

endmodule

// File: tb/tb_can_rx_msg_buffer_ctrl.sv
// Scoreboard bench for can_rx_msg_buffer_ctrl: stimulus queues expected FIFO entries,
// a negedge monitor compares the head fields on every host pop.
module tb_can_rx_msg_buffer_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done = 1'b0;
    logic [10:0] rx_id_std = '0;
    logic        rx_rtr = 1'b0;
    logic        rx_ide = 1'b0;
    logic [3:0]  rx_dlc = '0;
    logic [63:0] rx_data = '0;
    logic        cfg_filter_en = 1'b0;
    logic [10:0] cfg_acc_code = '0;
    logic [10:0] cfg_acc_mask = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [10:0] rd_id;
    logic        rd_rtr;
    logic        rd_ide;
    logic [3:0]  rd_dlc;
    logic [63:0] rd_data;
    logic [2:0]  fifo_count;
    logic        overrun;
    logic        clr_overrun = 1'b0;
    logic        msg_accepted;
    logic        msg_rejected;

    typedef struct packed {
        logic [10:0] id;
        logic        rtr;
        logic        ide;
        logic [3:0]  dlc;
        logic [63:0] data;
    } entry_t;

    entry_t exp_q[$];
    entry_t mon_e;
    int     total = 0;
    int     bad = 0;
    bit     pop_in_write = 1'b0;

    can_rx_msg_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_id_std(rx_id_std),
        .rx_rtr(rx_rtr), .rx_ide(rx_ide), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .cfg_filter_en(cfg_filter_en), .cfg_acc_code(cfg_acc_code), .cfg_acc_mask(cfg_acc_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id), .rd_rtr(rd_rtr),
        .rd_ide(rd_ide), .rd_dlc(rd_dlc), .rd_data(rd_data), .fifo_count(fifo_count),
        .overrun(overrun), .clr_overrun(clr_overrun),
        .msg_accepted(msg_accepted), .msg_rejected(msg_rejected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one frame from an IDLE cycle and returns once the FSM is back in IDLE.
    task automatic frame(input logic [10:0] id, input logic rtr, input logic ide,
                         input logic [3:0] dlc, input logic [63:0] data,
                         input logic [63:0] exp_data, input bit exp_acc, input bit exp_store);
        entry_t e;
        rx_id_std = id; rx_rtr = rtr; rx_ide = ide; rx_dlc = dlc; rx_data = data;
        rx_done = 1'b1;
        step;
        rx_done = 1'b0;
        rx_data = 64'hDEAD_DEAD_DEAD_DEAD;
        chk("msg_rejected", msg_rejected, !exp_acc);
        step;
        if (exp_acc) begin
            chk("msg_accepted", msg_accepted, exp_store);
            if (exp_store) begin
                e.id = id; e.rtr = rtr; e.ide = ide; e.dlc = dlc; e.data = exp_data;
                exp_q.push_back(e);
            end
            rd_ready = pop_in_write;
            step;
            rd_ready = 1'b0;
        end else begin
            chk("msg_rejected_low", msg_rejected, 1'b0);
        end
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) step;
        rd_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", rd_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_id", rd_id, mon_e.id);
                chk("pop_rtr", rd_rtr, mon_e.rtr);
                chk("pop_ide", rd_ide, mon_e.ide);
                chk("pop_dlc", rd_dlc, mon_e.dlc);
                chk("pop_data", rd_data, mon_e.data);
            end
        end
    end

    initial begin
        repeat (3) step;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_accepted", msg_accepted, 0);
        chk("rst_rejected", msg_rejected, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_id", rd_id, 0);
        rst_n = 1'b1;
        step;

        // Filter disabled, short frame with garbage in the unused bytes.
        frame(11'h123, 0, 0, 4'd2, 64'hAABB_1122_3344_5566, 64'hAABB_0000_0000_0000, 1, 1);
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_count", fifo_count, 1);
        chk("t1_rd_data", rd_data, 64'hAABB_0000_0000_0000);
        drain(1);
        chk("t1_rd_valid_after_pop", rd_valid, 0);

        // Acceptance filter.
        cfg_filter_en = 1'b1; cfg_acc_code = 11'h120; cfg_acc_mask = 11'h7F0;
        frame(11'h12F, 0, 1, 4'd1, 64'h5A00_0000_0000_0000, 64'h5A00_0000_0000_0000, 1, 1);
        frame(11'h130, 0, 0, 4'd1, 64'h6600_0000_0000_0000, 64'h0, 0, 0);
        chk("t2_count", fifo_count, 1);
        drain(1);
        cfg_filter_en = 1'b0;

        // Overflow: fifth frame is dropped.
        for (int i = 1; i <= 5; i++)
            frame(11'(i), 0, 0, 4'd8, {8{8'(i)}}, {8{8'(i)}}, 1, i <= 4);
        chk("t3_count", fifo_count, 4);
        chk("t3_overrun", overrun, 1);
        chk("t3_head_id", rd_id, 11'h001);
        clr_overrun = 1'b1; step; clr_overrun = 1'b0;
        chk("t3_overrun_cleared", overrun, 0);
        drain(4);

        // Pop during WRITE with 3 stored: count unchanged.
        for (int i = 0; i < 3; i++)
            frame(11'h010 + 11'(i), 0, 0, 4'd4, 64'h0102_0304_0506_0708, 64'h0102_0304_0000_0000, 1, 1);
        pop_in_write = 1'b1;
        frame(11'h013, 0, 0, 4'd4, 64'h0102_0304_0506_0708, 64'h0102_0304_0000_0000, 1, 1);
        pop_in_write = 1'b0;
        chk("t4_count_same", fifo_count, 3);
        chk("t4_overrun", overrun, 0);
        drain(3);

        // Pop during WRITE while full: still dropped.
        for (int i = 0; i < 4; i++)
            frame(11'h020 + 11'(i), 0, 0, 4'd8, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1, 1);
        pop_in_write = 1'b1;
        frame(11'h024, 0, 0, 4'd8, 64'h1111_2222_3333_4444, 64'h0, 1, 0);
        pop_in_write = 1'b0;
        chk("t4_full_pop_count", fifo_count, 3);
        chk("t4_full_pop_overrun", overrun, 1);
        clr_overrun = 1'b1; step; clr_overrun = 1'b0;
        drain(3);

        // Pointer wrap.
        for (int i = 0; i < 9; i++) begin
            frame(11'h300 + 11'(i), 0, 0, 4'd8, {8{8'(i + 16)}}, {8{8'(i + 16)}}, 1, 1);
            drain(1);
        end
        chk("t4_wrap_count", fifo_count, 0);

        // Remote frame, oversize DLC, mid-length and empty data frames.
        frame(11'h055, 1, 0, 4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1);
        frame(11'h066, 0, 1, 4'd12, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1, 1);
        frame(11'h077, 0, 0, 4'd3,  64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BE00_0000_0000, 1, 1);
        frame(11'h088, 0, 0, 4'd0,  64'h1234_5678_9ABC_DEF0, 64'h0, 1, 1);
        chk("t5_head_rd_data", rd_data, 64'h0);
        chk("t5_head_rtr", rd_rtr, 1);
        drain(4);

        // rx_done while busy: second frame dropped, first one stored.
        rx_id_std = 11'h0A1; rx_rtr = 0; rx_ide = 0; rx_dlc = 4'd2; rx_data = 64'hC0DE_0000_0000_0000;
        rx_done = 1'b1;
        step;
        rx_id_std = 11'h0A2; rx_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step;
        rx_done = 1'b0;
        chk("t6_accepted", msg_accepted, 1);
        mon_e.id = 11'h0A1; mon_e.rtr = 0; mon_e.ide = 0; mon_e.dlc = 4'd2; mon_e.data = 64'hC0DE_0000_0000_0000;
        exp_q.push_back(mon_e);
        step;
        chk("t6_overrun", overrun, 1);
        chk("t6_count", fifo_count, 1);
        chk("t6_head_id", rd_id, 11'h0A1);

        // Reset during WRITE with 2 entries stored.
        frame(11'h0B1, 0, 0, 4'd1, 64'h7700_0000_0000_0000, 64'h7700_0000_0000_0000, 1, 1);
        chk("t7_count_before", fifo_count, 2);
        rx_id_std = 11'h0B2; rx_dlc = 4'd1; rx_data = 64'h8800_0000_0000_0000;
        rx_done = 1'b1;
        step;
        rx_done = 1'b0;
        step;
        chk("t7_in_write", msg_accepted, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t7_rst_count", fifo_count, 0);
        chk("t7_rst_rd_valid", rd_valid, 0);
        chk("t7_rst_overrun", overrun, 0);
        chk("t7_rst_accepted", msg_accepted, 0);
        step;
        chk("t7_rst_accepted_hold", msg_accepted, 0);
        rst_n = 1'b1;
        step;
        frame(11'h7FF, 0, 1, 4'd8, 64'hA5A5_5A5A_A5A5_5A5A, 64'hA5A5_5A5A_A5A5_5A5A, 1, 1);
        chk("t7_count_after", fifo_count, 1);
        chk("t7_entry0_id", rd_id, 11'h7FF);
        drain(1);

        step;
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/can_rx_msg_buffer_ctrl.md
# can_rx_msg_buffer_ctrl

Receive-side message controller between the CAN frame receiver and the host/register interface. It captures each completed frame on the receiver's `rx_done` pulse, applies a programmable standard-ID acceptance filter, and writes accepted frames into a DEPTH-entry message FIFO. The host drains the FIFO with a valid/ready handshake. The block tracks overrun when a frame arrives and cannot be stored.

## Interface
- `DEPTH`, default 4: number of message entries; power of 2, minimum 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_done`  in  1  single-cycle pulse from the receiver; frame fields are valid in this cycle.
- `rx_id_std`  in  11  received standard identifier.
- `rx_rtr`  in  1  remote frame flag.
- `rx_ide`  in  1  extended-format flag.
- `rx_dlc`  in  4  received data length code.
- `rx_data`  in  64  received data; byte0 is in [63:56] and byte7 is in [7:0].
- `cfg_filter_en`  in  1  1 = apply the acceptance filter; 0 = accept all frames.
- `cfg_acc_code`  in  11  acceptance code.
- `cfg_acc_mask`  in  11  mask; bit=1 means that ID bit must match the code.
- `rd_valid`  out  1  FIFO head entry is available.
- `rd_ready`  in  1  host pops the head entry when `rd_valid` is also high.
- `rd_id`, `rd_rtr`, `rd_ide`, `rd_dlc`, `rd_data`  out  11/1/1/4/64  head entry fields.
- `fifo_count`  out  $clog2(DEPTH)+1  number of stored entries.
- `overrun`  out  1  sticky flag: at least one frame was lost.
- `clr_overrun`  in  1  clears `overrun`.
- `msg_accepted`  out  1  one-cycle pulse when a frame is written into the FIFO.
- `msg_rejected`  out  1  one-cycle pulse when a frame fails the acceptance filter.

## Operation
- FSM states are IDLE, FILTER and WRITE. The FSM resets to IDLE.
- **IDLE**
  - When `rx_done`=1, latch `rx_*` into staging registers and go to FILTER.
- **Data sanitising at capture**
  - Data bytes at index ≥ min(`rx_dlc`, 8) are forced to 0x00.
  - When `rx_rtr`=1, all data is forced to zero.
  - `rd_dlc` stores the raw `rx_dlc`, including values 9–15.
- **FILTER**
  - Sample the `cfg_*` inputs in this cycle.
  - Accept when `cfg_filter_en`=0, or when ((id ^ code) & mask) == 0.
  - Accept: go to WRITE.
  - Reject: pulse `msg_rejected` and return to IDLE.
- **WRITE**
  - If not full: write the staged entry at `wptr`, increment `wptr` and `fifo_count`, pulse `msg_accepted`.
  - If full (`fifo_count` == DEPTH): drop the frame, set `overrun`, leave the FIFO unchanged.
  - Return to IDLE in both cases.
- **rx_done while not in IDLE**
  - The new frame is dropped and `overrun` is set.
  - The frame in progress is unaffected.
- **Host read side**
  - `rd_valid` = (`fifo_count` != 0).
  - `rd_*` outputs are driven combinationally from the entry at `rptr`.
  - A pop (`rd_valid` & `rd_ready`) advances `rptr` and decrements `fifo_count` at the clock edge.
  - `rd_ready` while empty has no effect.
- **Pointers**
  - `wptr` and `rptr` are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Simultaneous events**
  - Write and pop in the same cycle: `fifo_count` is unchanged and both pointers advance.
  - Pop while full, in the same cycle as WRITE: the FIFO counts as full, so the frame is dropped and `overrun` is set. Full status is evaluated on the registered `fifo_count`.
  - `clr_overrun` and an overrun-set event in the same cycle: set wins.
- **Configuration changes**
  - Changes affect only frames whose FILTER cycle occurs after the change.

## Timing
- Reset values:
  - `rd_valid`=0, `fifo_count`=0, `overrun`=0, `msg_accepted`=0, `msg_rejected`=0.
  - All `rd_*` fields are 0, because storage entries reset to 0.
  - Both pointers are 0 and the FSM is in IDLE.
- Reset asserted mid-operation: every item above returns to its reset value immediately, and stored and in-flight frames are lost.
- Acceptance latency, with `rx_done` in cycle N:
  - FILTER in N+1.
  - WRITE in N+2, where `msg_accepted` is high.
  - `rd_valid`=1 and `fifo_count` is incremented from N+3.
- Rejection timing: `msg_rejected` is high in cycle N+1, and the FSM is in IDLE in N+2.
- Back-to-back capture: the block can accept a new `rx_done` every 3 cycles. Legal CAN frames are far longer than this.
- Pop timing: the head fields change in the cycle after the pop edge. `rd_valid` drops in that same cycle if the FIFO became empty.
- `overrun` rises in the cycle after the drop event.

## Test plan
- Filter disabled, one frame (id=0x123, dlc=2, data=AA BB, rest garbage) with `rx_done` at cycle 10 -> `msg_accepted` at cycle 12, `rd_valid` at cycle 13, `rd_data`=0xAABB000000000000, `fifo_count`=1.
- code=0x120, mask=0x7F0: frames with id 0x12F and id 0x130 -> 0x12F is stored and 0x130 produces a `msg_rejected` pulse; `fifo_count`=1.
- DEPTH=4: five accepted frames with no pops -> `fifo_count`=4, `overrun`=1, the head is frame 1 and the tail is frame 4; `clr_overrun` then brings `overrun` to 0.
- Fill to 3 entries, then hold `rd_ready` high across a WRITE cycle -> `fifo_count` stays 3; the pointer wrap is checked by writing and popping 9 frames in sequence.
- RTR frame with dlc=8, and a data frame with dlc=12 -> `rd_data`=0 for the RTR frame; the dlc=12 frame keeps all 8 bytes and `rd_dlc`=12.
- Assert `rst_n` while the FSM is in WRITE with 2 entries stored -> `fifo_count`=0, `rd_valid`=0, `overrun`=0, no `msg_accepted` pulse, and the next frame lands in entry 0.
